// File: rtl/uvmt_i2c_st_link_pkg.sv
// Shared types and constants for the self-test I2C link model.
package uvmt_i2c_st_link_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } link_state_e;

  // Level driven on every pair while the link is not running.
  localparam logic IDLE_P = 1'b1;
  localparam logic IDLE_N = 1'b0;

  localparam int DEFAULT_CNT_W = 16;

endpackage

// File: rtl/uvmt_i2c_st_delay_line.sv
// One direction of the link: ring buffer delay, registered outputs with
// optional per-lane inversion, and a saturating pair-violation counter.
module uvmt_i2c_st_delay_line
  import uvmt_i2c_st_link_pkg::*;
#(
  parameter int NUM_LANES = 1,
  parameter int MAX_DELAY = 8,
  parameter int CNT_W     = DEFAULT_CNT_W,
  parameter int DELAY_W   = $clog2(MAX_DELAY + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en_i,
  input  logic                 out_en_i,
  input  logic                 cnt_clr_i,
  input  logic                 cnt_en_i,
  input  logic [DELAY_W-1:0]   delay_i,
  input  logic [NUM_LANES-1:0] inj_mask_i,
  input  logic [NUM_LANES-1:0] p_i,
  input  logic [NUM_LANES-1:0] n_i,
  output logic [NUM_LANES-1:0] p_o,
  output logic [NUM_LANES-1:0] n_o,
  output logic [CNT_W-1:0]     viol_cnt_o
);

  localparam int PTR_W = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;

  logic [2*NUM_LANES-1:0] ring_mem [MAX_DELAY];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_idx;
  logic [DELAY_W:0]       rd_sum;
  logic [2*NUM_LANES-1:0] rd_word;
  logic [NUM_LANES-1:0]   p_q, n_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   any_viol;

  // Read index is the entry written d cycles ago; delay_i is always 1..MAX_DELAY.
  always_comb begin
    rd_sum = (DELAY_W+1)'(wr_ptr_q) + (DELAY_W+1)'(MAX_DELAY) - {1'b0, delay_i};
    if (rd_sum >= (DELAY_W+1)'(MAX_DELAY)) begin
      rd_sum = rd_sum - (DELAY_W+1)'(MAX_DELAY);
    end
    rd_idx   = PTR_W'(rd_sum);
    wr_ptr_d = (wr_ptr_q == PTR_W'(MAX_DELAY - 1)) ? '0 : wr_ptr_q + 1'b1;
  end

  assign rd_word  = ring_mem[rd_idx];
  assign any_viol = |(~(p_i ^ n_i));

  // Ring storage: plain array, no reset, so it can map onto RAM.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      ring_mem[wr_ptr_q] <= {p_i, n_i};
    end
  end

  // Write pointer advances on every buffered cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
    end else if (wr_en_i) begin
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // Registered outputs: delayed pair (optionally inverted) or idle level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_q <= {NUM_LANES{IDLE_P}};
      n_q <= {NUM_LANES{IDLE_N}};
    end else if (out_en_i) begin
      p_q <= rd_word[2*NUM_LANES-1:NUM_LANES] ^ inj_mask_i;
      n_q <= rd_word[NUM_LANES-1:0] ^ inj_mask_i;
    end else begin
      p_q <= {NUM_LANES{IDLE_P}};
      n_q <= {NUM_LANES{IDLE_N}};
    end
  end

  // Saturating violation counter, +1 per cycle regardless of lane count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (cnt_clr_i) begin
      cnt_q <= '0;
    end else if (cnt_en_i && any_viol && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign p_o        = p_q;
  assign n_o        = n_q;
  assign viol_cnt_o = cnt_q;

endmodule

// File: rtl/uvmt_i2c_st_link_model.sv
// Self-test link model: two delay lines (c2t, t2c) sharing one FSM,
// delay latch and fill counter. Fault injection is compiled in only when
// UVMT_I2C_ST_LINK_FAULT_INJ_EN is defined; otherwise inj_ack stays 0.
module uvmt_i2c_st_link_model
  import uvmt_i2c_st_link_pkg::*;
#(
  parameter int NUM_LANES = 1,
  parameter int MAX_DELAY = 8,
  parameter int CNT_W     = DEFAULT_CNT_W,
  localparam int DELAY_W  = $clog2(MAX_DELAY + 1),
  localparam int LANE_W   = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cfg_en,
  input  logic                 cfg_load,
  input  logic [DELAY_W-1:0]   cfg_delay,
  input  logic [NUM_LANES-1:0] c2t_p_i,
  input  logic [NUM_LANES-1:0] c2t_n_i,
  input  logic [NUM_LANES-1:0] t2c_p_i,
  input  logic [NUM_LANES-1:0] t2c_n_i,
  output logic [NUM_LANES-1:0] c2t_p_o,
  output logic [NUM_LANES-1:0] c2t_n_o,
  output logic [NUM_LANES-1:0] t2c_p_o,
  output logic [NUM_LANES-1:0] t2c_n_o,
  output logic                 busy,
  output logic [CNT_W-1:0]     c2t_viol_cnt,
  output logic [CNT_W-1:0]     t2c_viol_cnt,
  input  logic                 inj_req,
  input  logic                 inj_dir,
  input  logic [LANE_W-1:0]    inj_lane,
  output logic                 inj_ack
);

  link_state_e          state_q, state_d;
  logic [DELAY_W-1:0]   d_q, d_d, d_clamp;
  logic [DELAY_W-1:0]   fill_q, fill_d;
  logic                 busy_q, inj_ack_q;
  logic                 inj_fire;
  logic [NUM_LANES-1:0] c2t_mask, t2c_mask;
  logic                 wr_en, out_en, cnt_en;

  // Next state: disable beats load, load restarts the fill with the new delay.
  always_comb begin
    d_clamp = cfg_delay;
    if (cfg_delay == '0) begin
      d_clamp = DELAY_W'(1);
    end else if (cfg_delay > DELAY_W'(MAX_DELAY)) begin
      d_clamp = DELAY_W'(MAX_DELAY);
    end
    state_d = state_q;
    fill_d  = fill_q;
    d_d     = cfg_load ? d_clamp : d_q;
    if (!cfg_en) begin
      state_d = IDLE;
      fill_d  = '0;
    end else if (cfg_load) begin
      state_d = FILL;
      fill_d  = DELAY_W'(1);
    end else begin
      case (state_q)
        IDLE: begin
          state_d = FILL;
          fill_d  = DELAY_W'(1);
        end
        FILL: begin
          if (fill_q >= d_q) state_d = RUN;
          else               fill_d  = fill_q + 1'b1;
        end
        RUN:     state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  // Fill counter counts buffered writes; RUN begins once d fresh entries exist.
  assign wr_en  = (state_d != IDLE);
  assign out_en = (state_d == RUN);
  assign cnt_en = (state_q == RUN);

`ifdef UVMT_I2C_ST_LINK_FAULT_INJ_EN
  assign inj_fire = inj_req && (state_q == RUN) && (state_d == RUN);
  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_inj
    assign c2t_mask[gi] = inj_fire && !inj_dir && (int'(inj_lane) == gi);
    assign t2c_mask[gi] = inj_fire &&  inj_dir && (int'(inj_lane) == gi);
  end
`else
  logic unused_inj;
  assign unused_inj = ^{inj_req, inj_dir, inj_lane};
  assign inj_fire   = 1'b0;
  assign c2t_mask   = '0;
  assign t2c_mask   = '0;
`endif

  // State, delay latch, fill counter, busy and ack registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      d_q       <= DELAY_W'(1);
      fill_q    <= '0;
      busy_q    <= 1'b1;
      inj_ack_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      d_q       <= d_d;
      fill_q    <= fill_d;
      busy_q    <= (state_d != RUN);
      inj_ack_q <= inj_fire;
    end
  end

  uvmt_i2c_st_delay_line #(
    .NUM_LANES(NUM_LANES), .MAX_DELAY(MAX_DELAY), .CNT_W(CNT_W), .DELAY_W(DELAY_W)
  ) u_c2t (
    .clk(clk), .reset(reset), .wr_en_i(wr_en), .out_en_i(out_en),
    .cnt_clr_i(cfg_load), .cnt_en_i(cnt_en), .delay_i(d_q), .inj_mask_i(c2t_mask),
    .p_i(c2t_p_i), .n_i(c2t_n_i), .p_o(c2t_p_o), .n_o(c2t_n_o),
    .viol_cnt_o(c2t_viol_cnt)
  );

  uvmt_i2c_st_delay_line #(
    .NUM_LANES(NUM_LANES), .MAX_DELAY(MAX_DELAY), .CNT_W(CNT_W), .DELAY_W(DELAY_W)
  ) u_t2c (
    .clk(clk), .reset(reset), .wr_en_i(wr_en), .out_en_i(out_en),
    .cnt_clr_i(cfg_load), .cnt_en_i(cnt_en), .delay_i(d_q), .inj_mask_i(t2c_mask),
    .p_i(t2c_p_i), .n_i(t2c_n_i), .p_o(t2c_p_o), .n_o(t2c_n_o),
    .viol_cnt_o(t2c_viol_cnt)
  );

  assign busy    = busy_q;
  assign inj_ack = inj_ack_q;

endmodule

// File: tb/tb_uvmt_i2c_st_link_model.sv
// Directed bench for uvmt_i2c_st_link_model with NUM_LANES=2, MAX_DELAY=8.
// Injection checks depend on UVMT_I2C_ST_LINK_FAULT_INJ_EN.
module tb_uvmt_i2c_st_link_model;

  localparam int NL = 2;
  localparam int MD = 8;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          cfg_en, cfg_load;
  logic [3:0]    cfg_delay;
  logic [NL-1:0] c2t_p_i, c2t_n_i, t2c_p_i, t2c_n_i;
  logic [NL-1:0] c2t_p_o, c2t_n_o, t2c_p_o, t2c_n_o;
  logic          busy;
  logic [CW-1:0] c2t_viol_cnt, t2c_viol_cnt;
  logic          inj_req, inj_dir;
  logic [0:0]    inj_lane;
  logic          inj_ack;

  int n_checks = 0;
  int n_errors = 0;

  uvmt_i2c_st_link_model #(.NUM_LANES(NL), .MAX_DELAY(MD), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .cfg_en(cfg_en), .cfg_load(cfg_load), .cfg_delay(cfg_delay),
    .c2t_p_i(c2t_p_i), .c2t_n_i(c2t_n_i), .t2c_p_i(t2c_p_i), .t2c_n_i(t2c_n_i),
    .c2t_p_o(c2t_p_o), .c2t_n_o(c2t_n_o), .t2c_p_o(t2c_p_o), .t2c_n_o(t2c_n_o),
    .busy(busy), .c2t_viol_cnt(c2t_viol_cnt), .t2c_viol_cnt(t2c_viol_cnt),
    .inj_req(inj_req), .inj_dir(inj_dir), .inj_lane(inj_lane), .inj_ack(inj_ack)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_bg();
    c2t_p_i = 2'b10; c2t_n_i = 2'b01;
    t2c_p_i = 2'b01; t2c_n_i = 2'b10;
  endtask

  task automatic check_outs(input string tag, input logic [1:0] cp, input logic [1:0] cn,
                            input logic [1:0] tp, input logic [1:0] tn);
    check_val({tag, "_c2t_p"}, c2t_p_o, cp);
    check_val({tag, "_c2t_n"}, c2t_n_o, cn);
    check_val({tag, "_t2c_p"}, t2c_p_o, tp);
    check_val({tag, "_t2c_n"}, t2c_n_o, tn);
  endtask

  // Enable (optionally with a load) and measure how long busy stays high.
  task automatic fill_phase(input string tag, input bit do_load, input logic [3:0] cfg, input int exp_d);
    int   n;
    logic bad;
    cfg_en = 1'b1; cfg_load = do_load; cfg_delay = cfg;
    tick();
    cfg_load = 1'b0;
    n = 0; bad = 1'b0;
    while (busy === 1'b1 && n < 40) begin
      if (c2t_p_o !== 2'b11 || c2t_n_o !== 2'b00 || t2c_p_o !== 2'b11 || t2c_n_o !== 2'b00) bad = 1'b1;
      n++;
      tick();
    end
    check_val({tag, "_busy_len"}, n, exp_d);
    check_val({tag, "_fill_idle"}, {31'd0, bad}, 32'd0);
  endtask

  // One-cycle pulse on both directions must appear exactly d cycles later.
  task automatic pulse_test(input string tag, input int d);
    set_bg();
    repeat (d + 1) tick();
    c2t_p_i = 2'b01; c2t_n_i = 2'b10;
    t2c_p_i = 2'b10; t2c_n_i = 2'b01;
    tick();
    set_bg();
    for (int j = 0; j <= d + 1; j++) begin
      if (j > 0) tick();
      if (j == d) check_outs($sformatf("%s_j%0d", tag, j), 2'b01, 2'b10, 2'b10, 2'b01);
      else        check_outs($sformatf("%s_j%0d", tag, j), 2'b10, 2'b01, 2'b01, 2'b10);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    reset = 1'b1; cfg_en = 1'b0; cfg_load = 1'b0; cfg_delay = 4'd0;
    inj_req = 1'b0; inj_dir = 1'b0; inj_lane = 1'b0;
    set_bg();
    #2;
    check_outs("rst0", 2'b11, 2'b00, 2'b11, 2'b00);
    check_val("rst0_busy", busy, 1);
    check_val("rst0_c2t_cnt", c2t_viol_cnt, 0);
    check_val("rst0_t2c_cnt", t2c_viol_cnt, 0);
    check_val("rst0_ack", inj_ack, 0);
    tick(); tick();
    reset = 1'b0;
    tick();

    // Latency checks across the clamp boundaries.
    fill_phase("d3", 1'b1, 4'd3, 3);
    pulse_test("lat3", 3);
    fill_phase("d0", 1'b1, 4'd0, 1);
    pulse_test("lat1", 1);
    fill_phase("d15", 1'b1, 4'd15, 8);
    pulse_test("lat8", 8);
    fill_phase("d2", 1'b1, 4'd2, 2);
    pulse_test("lat2", 2);

    // Delay change 2->6 in RUN: stale entries must never appear.
    c2t_p_i = 2'b01; c2t_n_i = 2'b10; t2c_p_i = 2'b10; t2c_n_i = 2'b01;
    tick(); tick();
    cfg_load = 1'b1; cfg_delay = 4'd6;
    c2t_p_i = 2'b00; c2t_n_i = 2'b11; t2c_p_i = 2'b11; t2c_n_i = 2'b00;
    tick();
    cfg_load = 1'b0;
    set_bg();
    for (int j = 0; j < 6; j++) begin
      check_outs($sformatf("chg_idle%0d", j), 2'b11, 2'b00, 2'b11, 2'b00);
      check_val($sformatf("chg_busy%0d", j), busy, 1);
      tick();
    end
    check_outs("chg_first", 2'b00, 2'b11, 2'b11, 2'b00);
    check_val("chg_run", busy, 0);
    tick();
    check_outs("chg_bg", 2'b10, 2'b01, 2'b01, 2'b10);

    // Violation counting: +1 per cycle, per direction.
    for (int i = 0; i < 5; i++) begin
      c2t_p_i = 2'b11; c2t_n_i = 2'b01;
      if (i < 2) begin t2c_p_i = 2'b11; t2c_n_i = 2'b10; end
      else begin t2c_p_i = 2'b01; t2c_n_i = 2'b10; end
      tick();
    end
    c2t_p_i = 2'b11; c2t_n_i = 2'b11;
    tick();
    set_bg();
    tick();
    check_val("viol_c2t", c2t_viol_cnt, 6);
    check_val("viol_t2c", t2c_viol_cnt, 2);

    // Asynchronous reset mid-RUN.
    reset = 1'b1;
    #1;
    check_outs("rst_run", 2'b11, 2'b00, 2'b11, 2'b00);
    check_val("rst_run_busy", busy, 1);
    check_val("rst_run_c2t_cnt", c2t_viol_cnt, 0);
    check_val("rst_run_t2c_cnt", t2c_viol_cnt, 0);
    tick();
    reset = 1'b0;
    fill_phase("rst_d1", 1'b0, 4'd0, 1);
    pulse_test("lat_rst", 1);

    // Disable, then load while disabled: IDLE wins, delay still latched.
    cfg_en = 1'b0;
    tick();
    check_outs("dis", 2'b11, 2'b00, 2'b11, 2'b00);
    check_val("dis_busy", busy, 1);
    cfg_load = 1'b1; cfg_delay = 4'd4;
    tick();
    cfg_load = 1'b0;
    tick();
    check_val("dis_load_busy", busy, 1);
    fill_phase("late_d4", 1'b0, 4'd0, 4);

    // Saturation, then clear on load, no counting during FILL.
    c2t_p_i = 2'b11; c2t_n_i = 2'b01;
    repeat (65540) tick();
    check_val("sat", c2t_viol_cnt, 16'hFFFF);
    tick();
    check_val("sat_hold", c2t_viol_cnt, 16'hFFFF);
    cfg_load = 1'b1; cfg_delay = 4'd3;
    tick();
    cfg_load = 1'b0;
    check_val("load_clr", c2t_viol_cnt, 0);
    n = 0;
    while (busy === 1'b1 && n < 40) begin n++; tick(); end
    check_val("fill_nocount", c2t_viol_cnt, 0);
    tick();
    check_val("run_count", c2t_viol_cnt, 1);

    // Fault injection.
    set_bg();
    repeat (5) tick();
    inj_req = 1'b1; inj_dir = 1'b1; inj_lane = 1'b0;
    tick();
`ifdef UVMT_I2C_ST_LINK_FAULT_INJ_EN
    check_val("inj_ack1", inj_ack, 1);
    check_outs("inj_t2c0", 2'b10, 2'b01, 2'b00, 2'b11);
    inj_dir = 1'b0; inj_lane = 1'b1;
    tick();
    check_val("inj_ack2", inj_ack, 1);
    check_outs("inj_c2t1", 2'b00, 2'b11, 2'b01, 2'b10);
    inj_req = 1'b0;
    tick();
    check_val("inj_ack_off", inj_ack, 0);
    check_outs("inj_after", 2'b10, 2'b01, 2'b01, 2'b10);
`else
    check_val("inj_ack_off", inj_ack, 0);
    check_outs("inj_none", 2'b10, 2'b01, 2'b01, 2'b10);
    inj_req = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
